mem_sequencer: RTL and testbench
================================

MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 8, RAM address width.
REQ-002 DATA_W, 16, RAM data width.
REQ-003 RD_LAT, 1, RAM read latency in clocks; legal range 1..3.
REQ-004 Ports (name, direction, width, meaning): clk, in, 1, the single clock; all logic is rising-edge.
REQ-005 reset, in, 1, asynchronous, active-low reset.
REQ-006 req, in, 1, host access request, level, held until accepted.
REQ-007 rw, in, 1, 1 = write, 0 = read; sampled with req.
REQ-008 auto_inc, in, 1, 1 = use internal pointer instead of haddr; sampled with req.
REQ-009 haddr, in, ADDR_W, host address, also the pointer load value.
REQ-010 hwdata, in, DATA_W, host write data.
REQ-011 ptr_load, in, 1, load pointer from haddr.
REQ-012 busy, out, 1, high whenever the FSM is not in IDLE.
REQ-013 wack, out, 1, one-cycle write-complete pulse.
REQ-014 rvalid, out, 1, one-cycle read-data-valid pulse.
REQ-015 rdata, out, DATA_W, captured read data, held until the next read.
REQ-016 ptr, out, ADDR_W, current pointer value.
REQ-017 ram_we, out, 1, RAM write enable.
REQ-018 ram_addr, out, ADDR_W, RAM address.
REQ-019 ram_din, out, DATA_W, RAM write data.
REQ-020 ram_dout, in, DATA_W, RAM read data.

Function
REQ-021 FSM states: IDLE, WR, RD; reset state IDLE.
REQ-022 Acceptance: in IDLE with req=1 and ptr_load=0, latch rw, data and address (ptr if auto_inc=1, else haddr) into ram_addr/ram_din; next state WR if rw=1, else RD.
REQ-023 WR: lasts exactly 1 cycle with ram_we=1; at its end, state -> IDLE and wack=1 for the following cycle.
REQ-024 ram_we shall be 1 only in WR, never in IDLE or RD.
REQ-025 RD: hold ram_addr for RD_LAT+1 cycles using an internal down-counter; on the last cycle's edge, rdata <= ram_dout, rvalid <= 1, state -> IDLE.
REQ-026 Latency from acceptance edge (cycle 0): write -> ram_we in cycle 1, wack in cycle 2; read -> rvalid in cycle RD_LAT+2 (3 at default).
REQ-027 A new request may be accepted in the same cycle that wack or rvalid is high (back-to-back throughput).
REQ-028 ram_addr and ram_din hold their last values while in IDLE.
REQ-029 Pointer: when auto_inc=1, ptr increments by 1 at the acceptance edge, modulo 2^ADDR_W (255 -> 0 wrap).
REQ-030 ptr_load in IDLE: ptr <= haddr; the load wins over a simultaneous req, which stays pending.
REQ-031 ptr_load while busy is ignored.
REQ-032 req while busy is ignored (not queued); the host holds req.

Reset
REQ-033 Asserting reset (low) shall immediately force: state IDLE, busy 0, ram_we 0, wack 0, rvalid 0, ram_addr 0, ram_din 0, rdata 0, ptr 0, counter 0.
REQ-034 Reset mid-WR or mid-RD aborts the access with no wack or rvalid; after release, the first edge accepts a pending req.

Structure
REQ-035 Package mem_seq_pkg holds the state enumeration and the default ADDR_W/DATA_W/RD_LAT constants.
REQ-036 No sub-module; the latency counter and pointer are inline registers; the RAM is instantiated outside this block.

Verification
REQ-037 Write haddr=0x10, hwdata=0xBEEF -> ram_we high exactly cycle 1 with ram_addr=0x10 and ram_din=0xBEEF; wack cycle 2.
REQ-038 Read 0x10 after that write, RD_LAT=1 -> rvalid in cycle 3 with rdata=0xBEEF; ram_we stays 0.
REQ-039 ptr_load haddr=0xFE, then three auto_inc reads -> ram_addr 0xFE, 0xFF, 0x00; ptr ends at 0x01.
REQ-040 ptr_load=1 and req=1 in the same cycle with haddr=0x20 -> ptr=0x20, req accepted the next cycle using 0x20.
REQ-041 reset asserted in cycle 1 of a write -> ram_we falls immediately, no wack, and all outputs read zero.
REQ-042 Back-to-back: write then read held on req -> read accepted in the wack cycle; rvalid exactly 3 cycles later.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared constants for the memory access sequencer: default geometry,
// read latency and the FSM state encoding.
package mem_seq_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;
   localparam int RD_LAT_DEF = 1;

   // Width of the read-latency down-counter; covers RD_LAT up to 3.
   localparam int CNT_W = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WR   = 2'd1;
   localparam state_t ST_RD   = 2'd2;

endpackage

// File: rtl/mem_sequencer.sv
// Single-port RAM access sequencer. Accepts one host read or write at a
// time, drives the external RAM, and returns wack / rvalid pulses.
// An optional auto-increment pointer can replace the host address.
module mem_sequencer
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              rw,
   input  logic              auto_inc,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [DATA_W-1:0] hwdata,
   input  logic              ptr_load,
   output logic              busy,
   output logic              wack,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ptr,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   state_t            state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [ADDR_W-1:0] ptr_q,      ptr_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q,  ram_din_d;
   logic [DATA_W-1:0] rdata_q,    rdata_d;
   logic              wack_q,     wack_d;
   logic              rvalid_q,   rvalid_d;

   // Next-state logic: acceptance, write strobe, read latency countdown.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      rdata_d    = rdata_q;
      wack_d     = 1'b0;
      rvalid_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A pointer load takes priority; a concurrent req stays pending.
            if (ptr_load) begin
               ptr_d = haddr;
            end else if (req) begin
               ram_addr_d = auto_inc ? ptr_q : haddr;
               ram_din_d  = hwdata;
               if (auto_inc) begin
                  ptr_d = ptr_q + 1'b1;
               end
               if (rw) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
                  cnt_d   = CNT_W'(RD_LAT);
               end
            end
         end
         ST_WR: begin
            state_d = ST_IDLE;
            wack_d  = 1'b1;
         end
         ST_RD: begin
            // Address is held RD_LAT+1 cycles; data is sampled on the last.
            if (cnt_q == '0) begin
               rdata_d  = ram_dout;
               rvalid_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         rdata_q    <= '0;
         wack_q     <= 1'b0;
         rvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         rdata_q    <= rdata_d;
         wack_q     <= wack_d;
         rvalid_q   <= rvalid_d;
      end
   end

   // Write enable is decoded from state so it drops as soon as reset hits.
   assign ram_we   = (state_q == ST_WR);
   assign busy     = (state_q != ST_IDLE);
   assign wack     = wack_q;
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;
   assign ptr      = ptr_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer with a behavioural 1-cycle RAM.
module tb_mem_sequencer;

   logic        clk;
   logic        reset;
   logic        req;
   logic        rw;
   logic        auto_inc;
   logic [7:0]  haddr;
   logic [15:0] hwdata;
   logic        ptr_load;
   logic        busy;
   logic        wack;
   logic        rvalid;
   logic [15:0] rdata;
   logic [7:0]  ptr;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;

   logic        init_mem;
   logic [15:0] mem [256];

   typedef struct {
      bit          wr;
      logic [15:0] data;
      int          lat;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   checks;
   int   failures;

   mem_sequencer #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .rw       (rw),
      .auto_inc (auto_inc),
      .haddr    (haddr),
      .hwdata   (hwdata),
      .ptr_load (ptr_load),
      .busy     (busy),
      .wack     (wack),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .ptr      (ptr),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   function automatic logic [15:0] pat(input logic [7:0] a);
      return {8'hA5, a};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: synchronous write, one-cycle registered read.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
         ram_dout <= '0;
      end else begin
         if (ram_we) mem[ram_addr] <= ram_din;
         ram_dout <= mem[ram_addr];
      end
   end

   task test_reset;
      reset = 1'b0; init_mem = 1'b1;
      req = 0; rw = 0; auto_inc = 0; haddr = '0; hwdata = '0; ptr_load = 0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
      checks++; if (ram_we !== 1'b0 || wack !== 1'b0 || rvalid !== 1'b0) begin
         failures++; $display("FAIL rst_strobes got we=%b wack=%b rvalid=%b required=0", ram_we, wack, rvalid); end
      checks++; if (ram_addr !== 8'h00 || ram_din !== 16'h0000) begin
         failures++; $display("FAIL rst_ram_bus got addr=%h din=%h required=0", ram_addr, ram_din); end
      checks++; if (rdata !== 16'h0000 || ptr !== 8'h00) begin
         failures++; $display("FAIL rst_rdata_ptr got rdata=%h ptr=%h required=0", rdata, ptr); end
      init_mem = 1'b0; reset = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_after got=%b required=0", busy); end
   endtask

   task test_write;
      int we_cnt;
      we_cnt = 0;
      req = 1; rw = 1; auto_inc = 0; haddr = 8'h10; hwdata = 16'hBEEF;
      sbq.push_back('{1'b1, 16'h0000, 2});
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (ram_we) we_cnt++;
         if (n == 1) begin
            checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_din !== 16'hBEEF) begin
               failures++; $display("FAIL wr_cycle1 got we=%b addr=%h din=%h required we=1 addr=10 din=beef", ram_we, ram_addr, ram_din); end
            req = 0;
         end
         if (wack || rvalid) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++; $display("FAIL wr_sb_unexpected cycle=%0d wack=%b rvalid=%b required=none", n, wack, rvalid);
            end else begin
               e = sbq.pop_front();
               if (wack !== e.wr || n != e.lat || (!e.wr && rdata !== e.data)) begin
                  failures++; $display("FAIL wr_sb got wack=%b cycle=%0d rdata=%h required wr=%b cycle=%0d rdata=%h", wack, n, rdata, e.wr, e.lat, e.data); end
            end
         end
      end
      checks++; if (sbq.size() != 0) begin failures++; $display("FAIL wr_sb_missing got=%0d left required=0", sbq.size()); end
      sbq.delete();
      checks++; if (we_cnt != 1) begin failures++; $display("FAIL wr_we_cycles got=%0d required=1", we_cnt); end
      checks++; if (ram_addr !== 8'h10 || ram_din !== 16'hBEEF) begin
         failures++; $display("FAIL wr_idle_hold got addr=%h din=%h required 10/beef", ram_addr, ram_din); end
   endtask

   task test_read;
      int we_cnt;
      we_cnt = 0;
      req = 1; rw = 0; auto_inc = 0; haddr = 8'h10;
      sbq.push_back('{1'b0, 16'hBEEF, 3});
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (ram_we) we_cnt++;
         if (n == 1) req = 0;
         if (wack || rvalid) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++; $display("FAIL rd_sb_unexpected cycle=%0d wack=%b rvalid=%b required=none", n, wack, rvalid);
            end else begin
               e = sbq.pop_front();
               if (wack !== e.wr || n != e.lat || (!e.wr && rdata !== e.data)) begin
                  failures++; $display("FAIL rd_sb got wack=%b cycle=%0d rdata=%h required wr=%b cycle=%0d rdata=%h", wack, n, rdata, e.wr, e.lat, e.data); end
            end
         end
      end
      checks++; if (sbq.size() != 0) begin failures++; $display("FAIL rd_sb_missing got=%0d left required=0", sbq.size()); end
      sbq.delete();
      checks++; if (we_cnt != 0) begin failures++; $display("FAIL rd_we_seen got=%0d required=0", we_cnt); end
      checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_hold got=%h required=beef", rdata); end
   endtask

   task test_back_to_back;
      req = 1; rw = 1; auto_inc = 0; haddr = 8'h60; hwdata = 16'hCAFE;
      sbq.push_back('{1'b1, 16'h0000, 2});
      sbq.push_back('{1'b0, 16'hCAFE, 5});
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) rw = 0;
         if (n == 3) begin
            checks++; if (busy !== 1'b1 || ram_addr !== 8'h60 || ram_we !== 1'b0) begin
               failures++; $display("FAIL b2b_accept got busy=%b addr=%h we=%b required 1/60/0", busy, ram_addr, ram_we); end
            req = 0;
         end
         if (wack || rvalid) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++; $display("FAIL b2b_sb_unexpected cycle=%0d wack=%b rvalid=%b required=none", n, wack, rvalid);
            end else begin
               e = sbq.pop_front();
               if (wack !== e.wr || n != e.lat || (!e.wr && rdata !== e.data)) begin
                  failures++; $display("FAIL b2b_sb got wack=%b cycle=%0d rdata=%h required wr=%b cycle=%0d rdata=%h", wack, n, rdata, e.wr, e.lat, e.data); end
            end
         end
      end
      checks++; if (sbq.size() != 0) begin failures++; $display("FAIL b2b_sb_missing got=%0d left required=0", sbq.size()); end
      sbq.delete();
   endtask

   task test_ptr_wrap;
      logic [7:0] ea;
      ptr_load = 1; req = 0; haddr = 8'hFE;
      @(negedge clk);
      ptr_load = 0;
      checks++; if (ptr !== 8'hFE) begin failures++; $display("FAIL ptr_load got=%h required=fe", ptr); end
      for (int k = 0; k < 3; k++) begin
         ea = 8'hFE + 8'(k);
         req = 1; rw = 0; auto_inc = 1; haddr = 8'h55;
         for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
               checks++; if (ram_addr !== ea) begin failures++; $display("FAIL ptr_addr%0d got=%h required=%h", k, ram_addr, ea); end
               req = 0;
            end
            if (n == 3) begin
               checks++; if (rvalid !== 1'b1 || rdata !== pat(ea)) begin
                  failures++; $display("FAIL ptr_rd%0d got rvalid=%b rdata=%h required 1/%h", k, rvalid, rdata, pat(ea)); end
            end
         end
      end
      auto_inc = 0;
      checks++; if (ptr !== 8'h01) begin failures++; $display("FAIL ptr_final got=%h required=01", ptr); end
   endtask

   task test_load_req;
      ptr_load = 1; req = 1; rw = 0; auto_inc = 1; haddr = 8'h20;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         if (n == 1) begin
            checks++; if (busy !== 1'b0 || ptr !== 8'h20) begin
               failures++; $display("FAIL ldreq_load got busy=%b ptr=%h required 0/20", busy, ptr); end
            ptr_load = 0; haddr = 8'h33;
         end
         if (n == 2) begin
            checks++; if (busy !== 1'b1 || ram_addr !== 8'h20 || ptr !== 8'h21) begin
               failures++; $display("FAIL ldreq_accept got busy=%b addr=%h ptr=%h required 1/20/21", busy, ram_addr, ptr); end
            req = 0;
         end
         if (n == 4) begin
            checks++; if (rvalid !== 1'b1 || rdata !== pat(8'h20)) begin
               failures++; $display("FAIL ldreq_rd got rvalid=%b rdata=%h required 1/%h", rvalid, rdata, pat(8'h20)); end
         end
      end
      auto_inc = 0;
   endtask

   task test_reset_mid_write;
      req = 1; rw = 1; auto_inc = 0; haddr = 8'h40; hwdata = 16'h1234;
      @(negedge clk);
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL rstw_we_before got=%b required=1", ram_we); end
      reset = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b0 || busy !== 1'b0 || wack !== 1'b0 || rvalid !== 1'b0) begin
         failures++; $display("FAIL rstw_ctrl got we=%b busy=%b wack=%b rvalid=%b required 0", ram_we, busy, wack, rvalid); end
      checks++; if (ram_addr !== 8'h00 || ram_din !== 16'h0000 || rdata !== 16'h0000 || ptr !== 8'h00) begin
         failures++; $display("FAIL rstw_data got addr=%h din=%h rdata=%h ptr=%h required 0", ram_addr, ram_din, rdata, ptr); end
      @(negedge clk);
      checks++; if (wack !== 1'b0 || mem[8'h40] !== pat(8'h40)) begin
         failures++; $display("FAIL rstw_abort got wack=%b mem=%h required 0/%h", wack, mem[8'h40], pat(8'h40)); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h40) begin
         failures++; $display("FAIL rstw_pending got busy=%b we=%b addr=%h required 1/1/40", busy, ram_we, ram_addr); end
      req = 0;
      @(negedge clk);
      checks++; if (wack !== 1'b1) begin failures++; $display("FAIL rstw_wack got=%b required=1", wack); end
   endtask

   initial begin
      checks = 0; failures = 0;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_ptr_wrap();
      test_load_req();
      test_reset_mid_write();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
